// File: rtl/key_onehot_capture.sv
// Key front end: 2-FF sync, per-key debounce, press latching, one-hot issue with valid/ready.
// Define KEY_RR_ARB_EN for round-robin selection among pending keys; default is lowest-index priority.
module key_onehot_capture #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keys,
  output logic [7:0] onehot_out,
  output logic       onehot_valid,
  input  logic       onehot_ready,
  output logic [7:0] pending,
  output logic       dropped
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [7:0]       r_sync_p0;
  logic [7:0]       r_sync_p1;
  logic [7:0]       r_st_p2;
  logic [7:0]       r_st_d_p3;
  logic [CNT_W-1:0] r_cnt [8];

  logic [7:0] r_pending;
  logic       r_dropped;
  logic [0:0] r_state;
  logic [7:0] r_out;
  logic       r_valid;

  logic [7:0] w_press;
  logic [7:0] w_clear;
  logic       w_hs;
  logic [7:0] w_grant;

  // Sync (p0, p1) -> debounced level (p2) -> delayed level for edge detect (p3)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_st_p2   <= '0;
      r_st_d_p3 <= '0;
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else begin
      r_sync_p0 <= keys;
      r_sync_p1 <= r_sync_p0;
      r_st_d_p3 <= r_st_p2;
      for (int i = 0; i < 8; i++) begin
        if (r_sync_p1[i] == r_st_p2[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_st_p2[i] <= r_sync_p1[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_st_p2 & ~r_st_d_p3;
  assign w_hs    = (r_state == HOLD) && onehot_ready;
  assign w_clear = w_hs ? r_out : 8'h00;

  // Pending bitmap: a press in the same cycle as the clear wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clear) | w_press;
      r_dropped <= |(w_press & r_pending & ~w_clear);
    end
  end

`ifdef KEY_RR_ARB_EN
  logic [2:0] r_ptr;
  logic       w_found;

  function automatic logic [2:0] f_enc(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  always_comb begin
    w_grant = 8'h00;
    w_found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!w_found && r_pending[r_ptr + 3'(k)]) begin
        w_grant[r_ptr + 3'(k)] = 1'b1;
        w_found                = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ptr <= 3'd0;
    else if (w_hs) r_ptr <= f_enc(r_out) + 3'd1;
  end
`else
  // Isolate the lowest set bit
  assign w_grant = r_pending & (~r_pending + 8'd1);
`endif

  // Output stage: registered one-hot word, one IDLE cycle between grants
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_out   <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_pending != 8'h00) begin
            r_out   <= w_grant;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        default: begin
          if (onehot_ready) begin
            r_out   <= 8'h00;
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign onehot_out   = r_out;
  assign onehot_valid = r_valid;
  assign pending      = r_pending;
  assign dropped      = r_dropped;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Directed bench for key_onehot_capture with DEBOUNCE_CYCLES=4 (press-to-valid = 8 edges).
module tb_key_onehot_capture;

  logic       clk;
  logic       rst;
  logic [7:0] keys;
  logic [7:0] onehot_out;
  logic       onehot_valid;
  logic       onehot_ready;
  logic [7:0] pending;
  logic       dropped;

  int checks;
  int errors;

  key_onehot_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .keys         (keys),
    .onehot_out   (onehot_out),
    .onehot_valid (onehot_valid),
    .onehot_ready (onehot_ready),
    .pending      (pending),
    .dropped      (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    keys = 8'h00;
    onehot_ready = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    keys = 8'hFF;
    onehot_ready = 1'b0;
    tick(2);
    checks++;
    if (onehot_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", onehot_valid); end
    checks++;
    if (onehot_out !== 8'h00) begin errors++; $display("FAIL rst_out got %h exp 00", onehot_out); end
    checks++;
    if (pending !== 8'h00) begin errors++; $display("FAIL rst_pending got %h exp 00", pending); end
    checks++;
    if (dropped !== 1'b0) begin errors++; $display("FAIL rst_dropped got %b exp 0", dropped); end
    rst = 1'b0;
    tick(7);
    checks++;
    if (onehot_valid !== 1'b0) begin errors++; $display("FAIL rst_early_valid got %b exp 0", onehot_valid); end
    tick(1);
    checks++;
    if (onehot_valid !== 1'b1) begin errors++; $display("FAIL rst_lat_valid got %b exp 1", onehot_valid); end
    checks++;
    if (onehot_out !== 8'h01) begin errors++; $display("FAIL rst_lat_out got %h exp 01", onehot_out); end
    checks++;
    if (pending !== 8'hFF) begin errors++; $display("FAIL rst_lat_pending got %h exp ff", pending); end
  endtask

  task automatic test_single_press();
    do_reset();
    keys = 8'h20;
    tick(7);
    checks++;
    if (onehot_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", onehot_valid); end
    tick(1);
    checks++;
    if (onehot_out !== 8'h20 || onehot_valid !== 1'b1) begin
      errors++; $display("FAIL single_grant got %h/%b exp 20/1", onehot_out, onehot_valid);
    end
    tick(3);
    checks++;
    if (onehot_out !== 8'h20 || onehot_valid !== 1'b1) begin
      errors++; $display("FAIL single_hold got %h/%b exp 20/1", onehot_out, onehot_valid);
    end
    checks++;
    if (pending !== 8'h20) begin errors++; $display("FAIL single_pending got %h exp 20", pending); end
    onehot_ready = 1'b1;
    tick(1);
    onehot_ready = 1'b0;
    checks++;
    if (onehot_valid !== 1'b0 || onehot_out !== 8'h00) begin
      errors++; $display("FAIL single_ack got %h/%b exp 00/0", onehot_out, onehot_valid);
    end
    checks++;
    if (pending !== 8'h00) begin errors++; $display("FAIL single_ack_pending got %h exp 00", pending); end
    keys = 8'h00;
    tick(8);
  endtask

  task automatic test_bounce();
    int seen;
    do_reset();
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      keys = (k % 2 == 0) ? 8'h04 : 8'h00;
      for (int c = 0; c < 2; c++) begin
        tick(1);
        if (onehot_valid) seen++;
      end
    end
    keys = 8'h00;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (onehot_valid || pending != 8'h00) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL bounce_glitch got %0d exp 0", seen); end
    keys = 8'h04;
    tick(8);
    checks++;
    if (onehot_out !== 8'h04 || onehot_valid !== 1'b1) begin
      errors++; $display("FAIL bounce_hold got %h/%b exp 04/1", onehot_out, onehot_valid);
    end
    onehot_ready = 1'b1;
    tick(1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (onehot_valid) seen++;
    end
    onehot_ready = 1'b0;
    checks++;
    if (seen !== 0 || pending !== 8'h00) begin
      errors++; $display("FAIL bounce_once got %0d/%h exp 0/00", seen, pending);
    end
    keys = 8'h00;
    tick(8);
  endtask

  task automatic test_simultaneous();
    do_reset();
    keys = 8'h42;
    onehot_ready = 1'b1;
    tick(8);
    checks++;
    if (onehot_out !== 8'h02 || onehot_valid !== 1'b1) begin
      errors++; $display("FAIL simul_first got %h/%b exp 02/1", onehot_out, onehot_valid);
    end
    checks++;
    if (pending !== 8'h42) begin errors++; $display("FAIL simul_pending got %h exp 42", pending); end
    tick(1);
    checks++;
    if (onehot_valid !== 1'b0 || pending !== 8'h40) begin
      errors++; $display("FAIL simul_idle got %b/%h exp 0/40", onehot_valid, pending);
    end
    tick(1);
    checks++;
    if (onehot_out !== 8'h40 || onehot_valid !== 1'b1) begin
      errors++; $display("FAIL simul_second got %h/%b exp 40/1", onehot_out, onehot_valid);
    end
    tick(1);
    checks++;
    if (onehot_valid !== 1'b0 || pending !== 8'h00) begin
      errors++; $display("FAIL simul_done got %b/%h exp 0/00", onehot_valid, pending);
    end
    onehot_ready = 1'b0;
    keys = 8'h00;
    tick(8);
  endtask

  task automatic test_merge();
    int drops;
    int grants;
    do_reset();
    keys = 8'h08;
    tick(8);
    checks++;
    if (onehot_out !== 8'h08 || onehot_valid !== 1'b1) begin
      errors++; $display("FAIL merge_grant got %h/%b exp 08/1", onehot_out, onehot_valid);
    end
    keys = 8'h00;
    tick(8);
    keys = 8'h08;
    drops = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (dropped) drops++;
    end
    checks++;
    if (drops !== 1) begin errors++; $display("FAIL merge_drop got %0d exp 1", drops); end
    checks++;
    if (pending !== 8'h08 || onehot_out !== 8'h08) begin
      errors++; $display("FAIL merge_pending got %h/%h exp 08/08", pending, onehot_out);
    end
    onehot_ready = 1'b1;
    tick(1);
    grants = 0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (onehot_valid) grants++;
    end
    onehot_ready = 1'b0;
    checks++;
    if (grants !== 0 || pending !== 8'h00) begin
      errors++; $display("FAIL merge_single got %0d/%h exp 0/00", grants, pending);
    end
    keys = 8'h00;
    tick(8);
  endtask

  task automatic test_reset_mid_hold();
    int seen;
    do_reset();
    keys = 8'h10;
    tick(8);
    checks++;
    if (onehot_out !== 8'h10 || onehot_valid !== 1'b1) begin
      errors++; $display("FAIL rsthold_grant got %h/%b exp 10/1", onehot_out, onehot_valid);
    end
    rst = 1'b1;
    keys = 8'h00;
    tick(1);
    checks++;
    if (onehot_valid !== 1'b0 || pending !== 8'h00 || onehot_out !== 8'h00) begin
      errors++; $display("FAIL rsthold_clear got %b/%h/%h exp 0/00/00", onehot_valid, pending, onehot_out);
    end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (onehot_valid || pending != 8'h00) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rsthold_quiet got %0d exp 0", seen); end
    keys = 8'h10;
    tick(8);
    checks++;
    if (onehot_out !== 8'h10 || onehot_valid !== 1'b1) begin
      errors++; $display("FAIL rsthold_repress got %h/%b exp 10/1", onehot_out, onehot_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    keys = 8'h00;
    onehot_ready = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_merge();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
